// File: rtl/wb_gpio.sv
// wb_gpio: Wishbone slave GPIO with debounced inputs, per-bit edge capture
// and a level interrupt.
//
// Register map (word offset = wb_adr_i[4:2]):
//   0 IN    debounced inputs (read-only)
//   1 OUT   output register driving gpio_o
//   2 MASK  interrupt enable per input bit
//   3 PEND  captured edges, write-1-to-clear
//   4 EDGE  1 = capture rising edge, 0 = capture falling edge
//   5..7    unmapped: read 0, writes ignored, still acked
//
// Ports:
//   clk, reset_n              clock, asynchronous active-low reset
//   wb_adr_i/dat_i/sel_i      Wishbone address, write data, byte enables
//   wb_stb_i/cyc_i/we_i       Wishbone strobe, cycle, write enable
//   wb_dat_o/ack_o            registered read data (0 unless ack) and ack
//   gpio_i                    raw asynchronous inputs
//   gpio_o                    output register
//   intr                      level interrupt, |(PEND & MASK), registered
module wb_gpio #(
  parameter int unsigned in_width     = 9,
  parameter int unsigned out_width    = 4,
  parameter int unsigned debounce_div = 100000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [31:0]          wb_adr_i,
  input  logic [31:0]          wb_dat_i,
  output logic [31:0]          wb_dat_o,
  input  logic [3:0]           wb_sel_i,
  input  logic                 wb_stb_i,
  input  logic                 wb_cyc_i,
  input  logic                 wb_we_i,
  output logic                 wb_ack_o,
  input  logic [in_width-1:0]  gpio_i,
  output logic [out_width-1:0] gpio_o,
  output logic                 intr
);

  localparam int unsigned CNT_W = (debounce_div > 1) ? $clog2(debounce_div) : 1;

  localparam logic [2:0] ADR_IN   = 3'd0;
  localparam logic [2:0] ADR_OUT  = 3'd1;
  localparam logic [2:0] ADR_MASK = 3'd2;
  localparam logic [2:0] ADR_PEND = 3'd3;
  localparam logic [2:0] ADR_EDGE = 3'd4;

  // ---------------------------------------------------------------------
  // Bus handshake
  // ---------------------------------------------------------------------
  logic        ack_q, ack_d;
  logic [31:0] dat_q, dat_d;
  logic        req;
  logic        wr_en;
  logic [2:0]  reg_adr;
  logic [31:0] lane_mask;
  logic [31:0] rd_data;

  // Excluding the cycle that already carries ack makes a held strobe
  // acknowledge every second clock.
  assign req     = wb_cyc_i & wb_stb_i & ~ack_q;
  assign wr_en   = req & wb_we_i;
  assign reg_adr = wb_adr_i[4:2];

  assign lane_mask = {{8{wb_sel_i[3]}}, {8{wb_sel_i[2]}},
                      {8{wb_sel_i[1]}}, {8{wb_sel_i[0]}}};

  // Address bits outside [4:2] and data bits above the register widths
  // have no function.
  logic unused_bits;
  assign unused_bits = ^{wb_adr_i[31:5], wb_adr_i[1:0], wb_dat_i};

  // ---------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------
  logic [out_width-1:0] out_q, out_d;
  logic [in_width-1:0]  mask_q, mask_d;
  logic [in_width-1:0]  edge_sel_q, edge_sel_d;
  logic [in_width-1:0]  pend_q, pend_d;
  logic [in_width-1:0]  pend_clr;
  logic                 intr_q, intr_d;

  // ---------------------------------------------------------------------
  // Input conditioning
  // ---------------------------------------------------------------------
  logic [in_width-1:0] sync1_q, sync2_q;
  logic [CNT_W-1:0]    presc_q, presc_d;
  logic                tick;
  logic [in_width-1:0] samp0_q, samp0_d;
  logic [in_width-1:0] samp1_q, samp1_d;
  logic [in_width-1:0] agree;
  logic [in_width-1:0] in_q, in_d;
  logic [in_width-1:0] in_prev_q;
  logic [in_width-1:0] rise, fall, ev;

  assign tick = (presc_q == CNT_W'(debounce_div - 1));

  always_comb begin
    presc_d = presc_q + CNT_W'(1);
    if (tick) begin
      presc_d = '0;
    end
  end

  // The 3-sample window is the sample arriving on this tick plus the two
  // held in samp0/samp1, so IN can move on the same tick as the third
  // agreeing sample.
  assign agree = ~(sync2_q ^ samp0_q) & ~(samp0_q ^ samp1_q);

  always_comb begin
    samp0_d = samp0_q;
    samp1_d = samp1_q;
    in_d    = in_q;
    if (tick) begin
      samp0_d = sync2_q;
      samp1_d = samp0_q;
      in_d    = (agree & sync2_q) | (~agree & in_q);
    end
  end

  // ---------------------------------------------------------------------
  // Edge capture and interrupt
  // ---------------------------------------------------------------------
  assign rise = in_q & ~in_prev_q;
  assign fall = ~in_q & in_prev_q;
  assign ev   = (edge_sel_q & rise) | (~edge_sel_q & fall);

  // OR-ing ev after the clear makes a same-cycle set win over W1C.
  assign pend_d = (pend_q & ~pend_clr) | ev;
  assign intr_d = |(pend_q & mask_q);

  // ---------------------------------------------------------------------
  // Register writes (take effect on the ack edge)
  // ---------------------------------------------------------------------
  always_comb begin
    out_d      = out_q;
    mask_d     = mask_q;
    edge_sel_d = edge_sel_q;
    pend_clr   = '0;
    if (wr_en) begin
      case (reg_adr)
        ADR_OUT: begin
          out_d = (out_q & ~lane_mask[out_width-1:0]) |
                  (wb_dat_i[out_width-1:0] & lane_mask[out_width-1:0]);
        end
        ADR_MASK: begin
          mask_d = (mask_q & ~lane_mask[in_width-1:0]) |
                   (wb_dat_i[in_width-1:0] & lane_mask[in_width-1:0]);
        end
        ADR_PEND: begin
          pend_clr = wb_dat_i[in_width-1:0] & lane_mask[in_width-1:0];
        end
        ADR_EDGE: begin
          edge_sel_d = (edge_sel_q & ~lane_mask[in_width-1:0]) |
                       (wb_dat_i[in_width-1:0] & lane_mask[in_width-1:0]);
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------
  // Read mux
  // ---------------------------------------------------------------------
  always_comb begin
    rd_data = '0;
    case (reg_adr)
      ADR_IN:   rd_data = 32'(in_q);
      ADR_OUT:  rd_data = 32'(out_q);
      ADR_MASK: rd_data = 32'(mask_q);
      ADR_PEND: rd_data = 32'(pend_q);
      ADR_EDGE: rd_data = 32'(edge_sel_q);
      default:  rd_data = '0;
    endcase
  end

  assign ack_d = req;
  assign dat_d = req ? rd_data : 32'd0;

  // ---------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ack_q      <= 1'b0;
      dat_q      <= '0;
      out_q      <= '0;
      mask_q     <= '0;
      edge_sel_q <= '0;
      pend_q     <= '0;
      intr_q     <= 1'b0;
      sync1_q    <= '0;
      sync2_q    <= '0;
      presc_q    <= '0;
      samp0_q    <= '0;
      samp1_q    <= '0;
      in_q       <= '0;
      in_prev_q  <= '0;
    end else begin
      ack_q      <= ack_d;
      dat_q      <= dat_d;
      out_q      <= out_d;
      mask_q     <= mask_d;
      edge_sel_q <= edge_sel_d;
      pend_q     <= pend_d;
      intr_q     <= intr_d;
      sync1_q    <= gpio_i;
      sync2_q    <= sync1_q;
      presc_q    <= presc_d;
      samp0_q    <= samp0_d;
      samp1_q    <= samp1_d;
      in_q       <= in_d;
      in_prev_q  <= in_q;
    end
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign gpio_o   = out_q;
  assign intr     = intr_q;

endmodule

// File: tb/tb_wb_gpio.sv
module tb_wb_gpio;
  localparam int IW  = 9;
  localparam int OW  = 4;
  localparam int DIV = 4;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic [31:0]   wb_adr_i = '0;
  logic [31:0]   wb_dat_i = '0;
  logic [31:0]   wb_dat_o;
  logic [3:0]    wb_sel_i = '0;
  logic          wb_stb_i = 1'b0;
  logic          wb_cyc_i = 1'b0;
  logic          wb_we_i = 1'b0;
  logic          wb_ack_o;
  logic [IW-1:0] gpio_i = '0;
  logic [OW-1:0] gpio_o;
  logic          intr;

  wb_gpio #(.in_width(IW), .out_width(OW), .debounce_div(DIV)) dut (
    .clk(clk), .reset_n(reset_n),
    .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_dat_o(wb_dat_o),
    .wb_sel_i(wb_sel_i), .wb_stb_i(wb_stb_i), .wb_cyc_i(wb_cyc_i),
    .wb_we_i(wb_we_i), .wb_ack_o(wb_ack_o),
    .gpio_i(gpio_i), .gpio_o(gpio_o), .intr(intr)
  );

  always #5 clk = ~clk;

  // Clock edges since reset release; the prescaler ticks on every edge
  // whose count is a multiple of DIV.
  int ecnt = 0;
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) ecnt <= 0;
    else          ecnt <= ecnt + 1;
  end

  int errs = 0;
  int checks = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called #1 after a rising edge. Holds the strobe across the ack edge and
  // one more edge so a lingering ack or a second ack shows up.
  task automatic bus(input logic [2:0] a, input logic we, input logic [31:0] d,
                     input logic [3:0] s, output logic [31:0] rd);
    wb_adr_i = {27'd0, a, 2'b00};
    wb_dat_i = d;
    wb_sel_i = s;
    wb_we_i  = we;
    wb_cyc_i = 1'b1;
    wb_stb_i = 1'b1;
    #1 check("ack_before_edge", wb_ack_o, 0);
    @(posedge clk); #1;
    check("ack_after_one_cycle", wb_ack_o, 1);
    rd = wb_dat_o;
    @(posedge clk); #1;
    check("ack_single_cycle", wb_ack_o, 0);
    check("dat_zero_without_ack", wb_dat_o, 0);
    wb_cyc_i = 1'b0;
    wb_stb_i = 1'b0;
    wb_we_i  = 1'b0;
  endtask

  task automatic rd_chk(input logic [2:0] a, input logic [31:0] exp, input string name);
    logic [31:0] rd;
    bus(a, 1'b0, 32'd0, 4'hF, rd);
    check(name, rd, exp);
  endtask

  task automatic wr(input logic [2:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] rd;
    bus(a, 1'b1, d, s, rd);
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_ecnt(input int target);
    int guard = 0;
    while (ecnt != target && guard < 500) begin
      @(posedge clk); #1;
      guard++;
    end
    check("wait_edge_reached", ecnt, target);
  endtask

  // Edge on which IN follows an input driven just after edge m: the input
  // is visible out of the 2-flop synchroniser from edge m+3 on, and IN
  // moves on the third tick that samples it.
  function automatic int in_update_edge(input int m);
    int k = m + 3;
    while (k % DIV != 0) k++;
    return k + 2 * DIV;
  endfunction

  function automatic logic [31:0] lanes(input logic [3:0] s);
    logic [31:0] bm = '0;
    for (int b = 0; b < 4; b++) if (s[b]) bm |= 32'hFF << (8 * b);
    return bm;
  endfunction

  typedef struct {
    logic [2:0]  a;
    logic        we;
    logic [31:0] d;
    logic [3:0]  s;
    logic [31:0] exp_rd;
    logic [3:0]  exp_gpo;
  } vec_t;

  vec_t vt[$];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    logic [IW-1:0] gin;
    int m, t;
    logic [31:0] m_out, m_mask, m_edge, m_pend, m_in, bm, exp;

    // Reset state and basic register access
    for (int i = 0; i < 8; i++) vt.push_back('{3'(i), 1'b0, 32'd0, 4'hF, 32'd0, 4'h0});
    vt.push_back('{3'd1, 1'b1, 32'hFFFF_FFFF, 4'b0001, 32'd0, 4'hF});
    vt.push_back('{3'd1, 1'b0, 32'd0, 4'hF, 32'h0000_000F, 4'hF});
    vt.push_back('{3'd1, 1'b1, 32'h0000_0000, 4'b0000, 32'd0, 4'hF});
    vt.push_back('{3'd1, 1'b0, 32'd0, 4'hF, 32'h0000_000F, 4'hF});
    vt.push_back('{3'd1, 1'b1, 32'h0000_0000, 4'b1110, 32'd0, 4'hF});
    vt.push_back('{3'd1, 1'b1, 32'h0000_000A, 4'b0001, 32'd0, 4'hA});
    vt.push_back('{3'd1, 1'b0, 32'd0, 4'hF, 32'h0000_000A, 4'hA});
    vt.push_back('{3'd2, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0, 4'hA});
    vt.push_back('{3'd2, 1'b0, 32'd0, 4'hF, 32'h0000_01FF, 4'hA});
    vt.push_back('{3'd2, 1'b1, 32'h0000_0000, 4'b0001, 32'd0, 4'hA});
    vt.push_back('{3'd2, 1'b0, 32'd0, 4'hF, 32'h0000_0100, 4'hA});
    vt.push_back('{3'd2, 1'b1, 32'h0000_0000, 4'hF, 32'd0, 4'hA});
    vt.push_back('{3'd4, 1'b1, 32'h0000_0155, 4'b0010, 32'd0, 4'hA});
    vt.push_back('{3'd4, 1'b0, 32'd0, 4'hF, 32'h0000_0100, 4'hA});
    vt.push_back('{3'd4, 1'b1, 32'h0000_0000, 4'hF, 32'd0, 4'hA});
    vt.push_back('{3'd4, 1'b0, 32'd0, 4'hF, 32'h0000_0000, 4'hA});
    vt.push_back('{3'd0, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0, 4'hA});
    vt.push_back('{3'd6, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0, 4'hA});
    vt.push_back('{3'd3, 1'b1, 32'hFFFF_FFFF, 4'hF, 32'd0, 4'hA});
    vt.push_back('{3'd0, 1'b0, 32'd0, 4'hF, 32'h0000_0000, 4'hA});
    vt.push_back('{3'd6, 1'b0, 32'd0, 4'hF, 32'h0000_0000, 4'hA});
    vt.push_back('{3'd3, 1'b0, 32'd0, 4'hF, 32'h0000_0000, 4'hA});

    repeat (3) @(posedge clk);
    #1;
    check("reset_ack", wb_ack_o, 0);
    check("reset_dat", wb_dat_o, 0);
    check("reset_gpio_o", gpio_o, 0);
    check("reset_intr", intr, 0);
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk); #1;

    foreach (vt[i]) begin
      bus(vt[i].a, vt[i].we, vt[i].d, vt[i].s, rd);
      if (!vt[i].we) check($sformatf("vec%0d_rd", i), rd, vt[i].exp_rd);
      check($sformatf("vec%0d_gpio_o", i), gpio_o, vt[i].exp_gpo);
    end

    // Debounce latency and glitch rejection
    gpio_i[0] = 1'b1;
    wait_cycles(2 + 3 * DIV);
    rd_chk(3'd0, 32'h001, "in_after_latency");
    gpio_i[1] = 1'b1;
    wait_cycles(DIV);
    gpio_i[1] = 1'b0;
    wait_cycles(20);
    rd_chk(3'd0, 32'h001, "in_glitch_rejected");

    // Rising-edge capture and W1C
    wr(3'd4, 32'h001, 4'hF);
    wr(3'd2, 32'h001, 4'hF);
    gpio_i[0] = 1'b0;
    wait_cycles(20);
    rd_chk(3'd3, 32'h000, "pend_fall_ignored_when_rise");
    m = ecnt;
    gpio_i[0] = 1'b1;
    t = in_update_edge(m);
    wait_ecnt(t + 1);
    check("intr_not_yet", intr, 0);
    wait_ecnt(t + 2);
    check("intr_one_after_pend", intr, 1);
    rd_chk(3'd3, 32'h001, "pend_rise_set");
    wb_adr_i = {27'd0, 3'd3, 2'b00}; wb_dat_i = 32'h001; wb_sel_i = 4'hF;
    wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check("w1c_ack", wb_ack_o, 1);
    check("intr_still_on_ack_edge", intr, 1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    check("intr_clear_after_ack", intr, 0);
    rd_chk(3'd3, 32'h000, "pend_cleared");

    // Falling-edge capture; W1C coinciding with a new event
    wr(3'd4, 32'h000, 4'hF);
    wr(3'd2, 32'h002, 4'hF);
    gpio_i[1] = 1'b1;
    wait_cycles(20);
    rd_chk(3'd0, 32'h003, "in_both_high");
    rd_chk(3'd3, 32'h000, "pend_rise_ignored_when_fall");
    gpio_i[1] = 1'b0;
    wait_cycles(20);
    rd_chk(3'd3, 32'h002, "pend_fall_set");
    check("intr_fall", intr, 1);
    gpio_i[1] = 1'b1;
    wait_cycles(20);
    rd_chk(3'd3, 32'h002, "pend_held");
    m = ecnt;
    gpio_i[1] = 1'b0;
    t = in_update_edge(m);
    wait_ecnt(t);
    wb_adr_i = {27'd0, 3'd3, 2'b00}; wb_dat_i = 32'h002; wb_sel_i = 4'hF;
    wb_we_i = 1'b1; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check("collide_ack", wb_ack_o, 1);
    check("collide_intr_a", intr, 1);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
    @(posedge clk); #1;
    check("collide_intr_b", intr, 1);
    rd_chk(3'd3, 32'h002, "pend_set_wins");

    // Reset in the middle of a read (strobe seen, ack not yet)
    wr(3'd1, 32'h5, 4'hF);
    check("gpio_o_before_reset", gpio_o, 4'h5);
    gin = IW'($urandom_range(1, (1 << IW) - 1));
    wb_adr_i = {27'd0, 3'd3, 2'b00}; wb_we_i = 1'b0; wb_sel_i = 4'hF;
    wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    #2;
    reset_n = 1'b0;
    gpio_i = gin;
    #1;
    check("rst_ack", wb_ack_o, 0);
    check("rst_intr", intr, 0);
    check("rst_gpio_o", gpio_o, 0);
    check("rst_dat", wb_dat_o, 0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    rd_chk(3'd3, 32'h000, "rst_pend");
    rd_chk(3'd1, 32'h000, "rst_out");

    // Reset while ack is high drops it without a clock
    wb_adr_i = {27'd0, 3'd1, 2'b00}; wb_cyc_i = 1'b1; wb_stb_i = 1'b1;
    @(posedge clk); #1;
    check("ack_before_async_reset", wb_ack_o, 1);
    reset_n = 1'b0;
    #1;
    check("ack_async_drop", wb_ack_o, 0);
    wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(posedge clk); #1;
    wait_cycles(30);
    rd_chk(3'd0, 32'(gin), "in_after_reset");

    // Randomised register traffic against the register-map model
    m_out = 0; m_mask = 0; m_edge = 0; m_pend = 0; m_in = 32'(gin);
    for (int i = 0; i < 60; i++) begin
      logic [2:0] a;
      logic we;
      logic [31:0] d;
      logic [3:0] s;
      a  = 3'($urandom_range(0, 7));
      we = 1'($urandom_range(0, 1));
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      case (a)
        3'd0: exp = m_in;
        3'd1: exp = m_out;
        3'd2: exp = m_mask;
        3'd3: exp = m_pend;
        3'd4: exp = m_edge;
        default: exp = 0;
      endcase
      bus(a, we, d, s, rd);
      if (!we) begin
        check($sformatf("rand%0d_rd_a%0d", i, a), rd, exp);
      end else begin
        bm = lanes(s);
        case (a)
          3'd1: m_out  = ((m_out  & ~bm) | (d & bm)) & 32'h00F;
          3'd2: m_mask = ((m_mask & ~bm) | (d & bm)) & 32'h1FF;
          3'd3: m_pend = m_pend & ~(d & bm);
          3'd4: m_edge = ((m_edge & ~bm) | (d & bm)) & 32'h1FF;
          default: ;
        endcase
      end
      check($sformatf("rand%0d_gpio_o", i), gpio_o, m_out);
      check($sformatf("rand%0d_intr", i), intr, ((m_pend & m_mask) != 0) ? 1 : 0);
    end

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
